// File: rtl/hamming_secded_apb.sv
// -----------------------------------------------------------------------------
// hamming_secded_apb
//   APB-attached Hamming SEC-DED codec. Software writes a data word to ENC_DATA
//   or a codeword to DEC_CODE. The block is then busy for LAT cycles, after
//   which it publishes the encoded codeword, or the corrected data together
//   with the syndrome and SEC/DED flags. Saturating SEC/DED counters and a
//   level interrupt report decode errors.
//
// Codeword layout: bit i (1..N-1) is Hamming position i. Parity sits at the
//   power-of-two positions and data fills the other positions in ascending
//   order. Bit 0 is even parity over bits 1..N-1.
//
// Ports
//   PCLK, PRESETn        clock, asynchronous active-low reset
//   PSEL, PENABLE,       APB request; only PADDR[7:2] is decoded
//   PWRITE, PADDR, PWDATA
//   PRDATA, PREADY,      APB response. Codec registers stall while busy.
//   PSLVERR
//   IRQ                  STATUS.ERR_IRQ & CTRL.IRQ_EN
// -----------------------------------------------------------------------------
module hamming_secded_apb #(
  parameter int DATA_W = 8,
  parameter int LAT    = 2
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        IRQ
);

  // Smallest P with 2^P >= DATA_W + P + 1.
  function automatic int calc_p(input int dw);
    int res;
    res = 0;
    for (int p = 6; p >= 1; p--) if ((1 << p) >= dw + p + 1) res = p;
    return res;
  endfunction

  localparam int P = calc_p(DATA_W);
  localparam int N = DATA_W + P + 1;

  localparam logic [5:0] A_CTRL     = 6'd0;
  localparam logic [5:0] A_STATUS   = 6'd1;
  localparam logic [5:0] A_ENC_DATA = 6'd2;
  localparam logic [5:0] A_ENC_CODE = 6'd3;
  localparam logic [5:0] A_DEC_CODE = 6'd4;
  localparam logic [5:0] A_DEC_DATA = 6'd5;
  localparam logic [5:0] A_SYNDROME = 6'd6;
  localparam logic [5:0] A_COUNTERS = 6'd7;

  typedef enum logic {S_IDLE, S_BUSY} state_e;
  typedef enum logic {M_ENC, M_DEC} mode_e;

  function automatic logic [N-1:0] encode(input logic [DATA_W-1:0] d);
    logic [N-1:0] c;
    int k;
    c = '0;
    k = 0;
    for (int i = 1; i < N; i++) begin
      if ((i & (i - 1)) != 0) begin
        c[i] = d[k];
        k++;
      end
    end
    for (int j = 0; j < P; j++)
      for (int i = 1; i < N; i++)
        if (((i >> j) & 1) == 1 && (i & (i - 1)) != 0) c[1 << j] = c[1 << j] ^ c[i];
    c[0] = ^c[N-1:1];
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [N-1:0] c);
    logic [DATA_W-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int i = 1; i < N; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[k] = c[i];
        k++;
      end
    end
    return d;
  endfunction

  state_e            state_q;
  mode_e             mode_q;
  logic [2:0]        cnt_q;
  logic [N-1:0]      op_q;
  logic              stall_q;
  logic              irq_en_q, done_q, sec_q, ded_q, err_irq_q;
  logic [N-1:0]      enc_code_q;
  logic [DATA_W-1:0] dec_data_q;
  logic [P:0]        syn_q;
  logic [15:0]       sec_cnt_q, ded_cnt_q;

  logic [5:0] idx;
  logic       access, err, is_codec, stall, xfer, start, fin, fin_dec, cnt_clr, w1c;
  logic [31:0] rdata;

  assign idx    = PADDR[7:2];
  assign access = PSEL & PENABLE;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    err      = 1'b1;
    is_codec = 1'b0;
    case (idx)
      A_CTRL, A_STATUS:                      err = 1'b0;
      A_ENC_DATA, A_DEC_CODE:                begin err = ~PWRITE; is_codec = 1'b1; end
      A_ENC_CODE, A_DEC_DATA, A_SYNDROME:    begin err = PWRITE;  is_codec = 1'b1; end
      A_COUNTERS:                            err = PWRITE;
      default:                               err = 1'b1;
    endcase
  end

  // A codec access that is stalled during BUSY is also held for the first
  // IDLE cycle (stall_q), so it completes in the cycle after that.
  assign stall   = access & ~err & is_codec & ((state_q == S_BUSY) | stall_q);
  assign PREADY  = ~stall;
  assign PSLVERR = access & err;
  assign xfer    = access & ~err & ~stall;
  assign start   = xfer & PWRITE & ((idx == A_ENC_DATA) | (idx == A_DEC_CODE));
  assign fin     = (state_q == S_BUSY) && (cnt_q == 3'd0);
  assign fin_dec = fin && (mode_q == M_DEC);
  assign cnt_clr = xfer & PWRITE & (idx == A_CTRL) & PWDATA[1];
  assign w1c     = xfer & PWRITE & (idx == A_STATUS) & PWDATA[4];

  // Decode datapath from the latched operand.
  logic [P-1:0]      dec_syn;
  logic              dec_par, dec_sec, dec_ded;
  logic [N-1:0]      dec_fix;
  logic [DATA_W-1:0] dec_data;

  always_comb begin
    dec_syn = '0;
    for (int i = 1; i < N; i++) if (op_q[i]) dec_syn = dec_syn ^ P'(i);
    dec_par = ^op_q;
    dec_sec = dec_par && (int'(dec_syn) < N);
    // A syndrome beyond the codeword with odd parity cannot be a single flip.
    dec_ded = (dec_par && int'(dec_syn) >= N) || (!dec_par && dec_syn != '0);
    dec_fix = op_q;
    if (dec_sec) dec_fix[dec_syn] = ~op_q[dec_syn];
    dec_data = extract(dec_fix);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= S_IDLE;
      mode_q     <= M_ENC;
      cnt_q      <= '0;
      op_q       <= '0;
      stall_q    <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      sec_q      <= 1'b0;
      ded_q      <= 1'b0;
      err_irq_q  <= 1'b0;
      enc_code_q <= '0;
      dec_data_q <= '0;
      syn_q      <= '0;
      sec_cnt_q  <= '0;
      ded_cnt_q  <= '0;
    end else begin
      stall_q <= access & ~err & is_codec & (state_q == S_BUSY);
      if (xfer && PWRITE && idx == A_CTRL) irq_en_q <= PWDATA[0];

      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (idx == A_ENC_DATA) begin
              op_q   <= N'(PWDATA[DATA_W-1:0]);
              mode_q <= M_ENC;
            end else begin
              op_q   <= PWDATA[N-1:0];
              mode_q <= M_DEC;
            end
            state_q <= S_BUSY;
            cnt_q   <= 3'(LAT - 1);
            done_q  <= 1'b0;
            sec_q   <= 1'b0;
            ded_q   <= 1'b0;
          end
        end
        S_BUSY: begin
          if (cnt_q == 3'd0) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            if (mode_q == M_ENC) begin
              enc_code_q <= encode(op_q[DATA_W-1:0]);
            end else begin
              dec_data_q <= dec_data;
              syn_q      <= {dec_par, dec_syn};
              sec_q      <= dec_sec;
              ded_q      <= dec_ded;
            end
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Clear beats a same-cycle increment.
      if (cnt_clr) begin
        sec_cnt_q <= '0;
        ded_cnt_q <= '0;
      end else begin
        if (fin_dec && dec_sec && sec_cnt_q != 16'hFFFF) sec_cnt_q <= sec_cnt_q + 16'd1;
        if (fin_dec && dec_ded && ded_cnt_q != 16'hFFFF) ded_cnt_q <= ded_cnt_q + 16'd1;
      end

      // A new DED event beats a same-cycle W1C.
      if (fin_dec && dec_ded) err_irq_q <= 1'b1;
      else if (w1c)          err_irq_q <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (idx)
      A_CTRL:     rdata = {31'b0, irq_en_q};
      A_STATUS:   rdata = {27'b0, err_irq_q, ded_q, sec_q, done_q, state_q == S_BUSY};
      A_ENC_CODE: rdata = 32'(enc_code_q);
      A_DEC_DATA: rdata = 32'(dec_data_q);
      A_SYNDROME: rdata = 32'(syn_q);
      A_COUNTERS: rdata = {ded_cnt_q, sec_cnt_q};
      default:    rdata = '0;
    endcase
  end

  assign PRDATA = (xfer && !PWRITE) ? rdata : 32'd0;
  assign IRQ    = err_irq_q & irq_en_q;

  logic unused_bits;
  assign unused_bits = ^{PADDR[31:8], PADDR[1:0], PWDATA};

endmodule
